// File: rtl/parking_spot_manager.sv
// Parking-lot controller: synchronises the gate sensors, checks each entry/exit
// against the DIP-selected spot, and drives the timed grant/deny traffic sign.
module parking_spot_manager #(
  parameter int NUM_SPOTS   = 8,
  parameter int CNT_W       = 4,
  parameter int SIGN_HOLD   = 50000000,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InSensor,
  input  logic                 OutSensor,
  input  logic [NUM_SPOTS-1:0] SpotSel,
  output logic [NUM_SPOTS-1:0] SpotMap,
  output logic [CNT_W-1:0]     QntFull,
  output logic [CNT_W-1:0]     QntFree,
  output logic [CNT_W-1:0]     SelIndex,
  output logic [2:0]           TrafficSign,
  output logic [1:0]           DenyCode
);

  localparam int TMR_W = (SIGN_HOLD > 2) ? $clog2(SIGN_HOLD) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(SIGN_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NUM_SPOTS);

  localparam logic [1:0] DC_NONE     = 2'd0;
  localparam logic [1:0] DC_INVALID  = 2'd1;
  localparam logic [1:0] DC_MISMATCH = 2'd2;
  localparam logic [1:0] DC_COLLIDE  = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_GRANT = 3'b010,
    ST_DENY  = 3'b100
  } sign_state_e;

  // ---------------------------------------------------------------------------
  // Sensor synchronisers and falling-edge detectors (index 0 entry, 1 exit).
  // Flops reset to 0 so an idle-high sensor cannot look like a fall on release.
  // ---------------------------------------------------------------------------
  logic [1:0] sensor_raw;
  logic [1:0] sensor_pulse;

  assign sensor_raw = {OutSensor, InSensor};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
      logic [SYNC_STAGES-1:0] sync_q;
      logic                   prev_q;

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          sync_q <= '0;
          prev_q <= 1'b0;
        end else begin
          sync_q <= {sync_q[SYNC_STAGES-2:0], sensor_raw[gi]};
          prev_q <= sync_q[SYNC_STAGES-1];
        end
      end

      assign sensor_pulse[gi] = prev_q & ~sync_q[SYNC_STAGES-1];
    end
  endgenerate

  logic entry_ev;
  logic exit_ev;

  assign entry_ev = sensor_pulse[0];
  assign exit_ev  = sensor_pulse[1];

  // ---------------------------------------------------------------------------
  // Spot selection decode
  // ---------------------------------------------------------------------------
  logic             sel_valid;
  logic [CNT_W-1:0] sel_idx;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_SPOTS; i++) begin
      if (SpotSel[i]) sel_idx = CNT_W'(i + 1);
    end
  end

  assign sel_valid = $onehot(SpotSel);
  assign SelIndex  = sel_valid ? sel_idx : '0;

  // ---------------------------------------------------------------------------
  // Occupancy state, sign state machine and hold timer
  // ---------------------------------------------------------------------------
  logic [NUM_SPOTS-1:0] map_q, map_d;
  logic [CNT_W-1:0]     full_q, full_d;
  sign_state_e          state_q, state_d;
  logic [TMR_W-1:0]     timer_q, timer_d;
  logic [1:0]           code_q, code_d;
  logic                 sel_free;

  // With a one-hot selection this is simply the free bit of the chosen spot.
  assign sel_free = |(map_q & SpotSel);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      map_q   <= '1;
      full_q  <= '0;
      state_q <= ST_IDLE;
      timer_q <= '0;
      code_q  <= DC_NONE;
    end else begin
      map_q   <= map_d;
      full_q  <= full_d;
      state_q <= state_d;
      timer_q <= timer_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    map_d   = map_q;
    full_d  = full_q;
    state_d = state_q;
    timer_d = timer_q;
    code_d  = code_q;

    // Hold countdown; a resolved event below overrides it.
    if (state_q != ST_IDLE) begin
      if (timer_q == '0) begin
        state_d = ST_IDLE;
      end else begin
        timer_d = timer_q - TMR_W'(1);
      end
    end

    if (entry_ev || exit_ev) begin
      timer_d = TMR_LOAD;
      state_d = ST_DENY;
      if (entry_ev && exit_ev) begin
        code_d = DC_COLLIDE;
      end else if (!sel_valid) begin
        code_d = DC_INVALID;
      end else if (entry_ev) begin
        if (sel_free && (full_q != CNT_MAX)) begin
          map_d   = map_q & ~SpotSel;
          full_d  = full_q + CNT_W'(1);
          state_d = ST_GRANT;
          code_d  = DC_NONE;
        end else begin
          code_d = DC_MISMATCH;
        end
      end else begin
        if (!sel_free && (full_q != '0)) begin
          map_d   = map_q | SpotSel;
          full_d  = full_q - CNT_W'(1);
          state_d = ST_GRANT;
          code_d  = DC_NONE;
        end else begin
          code_d = DC_MISMATCH;
        end
      end
    end
  end

  assign SpotMap     = map_q;
  assign QntFull     = full_q;
  assign QntFree     = CNT_MAX - full_q;
  assign TrafficSign = state_q;
  assign DenyCode    = code_q;

endmodule

// File: tb/tb_parking_spot_manager.sv
// Directed plus randomised bench for parking_spot_manager, checked every cycle
// against an event-level model of the lot and the sign timing.
module tb_parking_spot_manager;

  localparam int N = 8;
  localparam int W = 4;
  localparam int H = 20;
  localparam int S = 2;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         InSensor;
  logic         OutSensor;
  logic [N-1:0] SpotSel;
  logic [N-1:0] SpotMap;
  logic [W-1:0] QntFull;
  logic [W-1:0] QntFree;
  logic [W-1:0] SelIndex;
  logic [2:0]   TrafficSign;
  logic [1:0]   DenyCode;

  parking_spot_manager #(
    .NUM_SPOTS(N), .CNT_W(W), .SIGN_HOLD(H), .SYNC_STAGES(S)
  ) dut (
    .Clk(Clk), .Reset(Reset), .InSensor(InSensor), .OutSensor(OutSensor),
    .SpotSel(SpotSel), .SpotMap(SpotMap), .QntFull(QntFull), .QntFree(QntFree),
    .SelIndex(SelIndex), .TrafficSign(TrafficSign), .DenyCode(DenyCode)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // Reference model: occupancy per spot, last resolved event and its cycle.
  bit         occ [N];
  bit         have_ev;
  int         ev_cyc;
  logic [2:0] ev_sign;
  logic [1:0] code_m;

  typedef struct {
    int edge_c;
    bit ent;
    bit ext;
  } ev_t;
  ev_t pend[$];

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    compared++;
    assert (obs === req) else begin
      mismatched++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, req);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < N; i++) occ[i] = 1'b0;
    have_ev = 1'b0;
    ev_cyc  = 0;
    ev_sign = 3'b001;
    code_m  = 2'd0;
    pend.delete();
  endfunction

  function automatic void apply(input bit ent, input bit ext);
    int n;
    int idx;
    int used;
    bit ok;
    n = 0; idx = 0; used = 0; ok = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SpotSel[i]) begin n++; idx = i; end
      used += int'(occ[i]);
    end
    if (ent && ext)      code_m = 2'd3;
    else if (n != 1)     code_m = 2'd1;
    else if (ent) begin
      if (!occ[idx] && used < N) begin occ[idx] = 1'b1; ok = 1'b1; end
      else code_m = 2'd2;
    end else begin
      if (occ[idx] && used > 0) begin occ[idx] = 1'b0; ok = 1'b1; end
      else code_m = 2'd2;
    end
    if (ok) code_m = 2'd0;
    have_ev = 1'b1;
    ev_cyc  = cyc;
    ev_sign = ok ? 3'b010 : 3'b100;
    $display("EVENT cyc=%0d entry=%0b exit=%0b sel=%b -> sign=%b code=%0d full=%0d",
             cyc, ent, ext, SpotSel, ev_sign, code_m, used + (ok ? (ent ? 1 : -1) : 0));
  endfunction

  task automatic check_all();
    logic [N-1:0] m;
    logic [2:0]   sg;
    int used;
    int n;
    int idx;
    used = 0; n = 0; idx = 0;
    for (int i = 0; i < N; i++) begin
      m[i] = ~occ[i];
      used += int'(occ[i]);
      if (SpotSel[i]) begin n++; idx = i + 1; end
    end
    sg = (have_ev && (cyc - ev_cyc) < H) ? ev_sign : 3'b001;
    chk("spotmap",  32'(SpotMap),     32'(m));
    chk("qntfull",  32'(QntFull),     32'(used));
    chk("qntfree",  32'(QntFree),     32'(N - used));
    chk("selindex", 32'(SelIndex),    32'((n == 1) ? idx : 0));
    chk("sign",     32'(TrafficSign), 32'(sg));
    chk("denycode", 32'(DenyCode),    32'(code_m));
  endtask

  task automatic step();
    @(negedge Clk);
    while (pend.size() > 0 && pend[0].edge_c == cyc) begin
      apply(pend[0].ent, pend[0].ext);
      void'(pend.pop_front());
    end
    check_all();
  endtask

  // Called at a negedge; the fall precedes the next edge k, result lands at k+S.
  task automatic fall(input bit ent, input bit ext);
    ev_t e;
    if (ent) InSensor  = 1'b0;
    if (ext) OutSensor = 1'b0;
    e.edge_c = cyc + 1 + S;
    e.ent = ent;
    e.ext = ext;
    pend.push_back(e);
  endtask

  task automatic run_event(input bit ent, input bit ext, input int hold, input int gap);
    fall(ent, ext);
    repeat (hold) step();
    InSensor  = 1'b1;
    OutSensor = 1'b1;
    repeat (gap) step();
  endtask

  task automatic select(input int spot);
    SpotSel = '0;
    SpotSel[spot] = 1'b1;
  endtask

  initial begin
    Reset = 1'b1; InSensor = 1'b1; OutSensor = 1'b1; SpotSel = '0;
    model_reset();
    #1 check_all();
    @(negedge Clk) Reset = 1'b0;
    repeat (3) step();

    // Entry on spot 3, then a second entry on the same spot.
    select(2);
    step();
    run_event(1'b1, 1'b0, 2, H + 4);
    run_event(1'b1, 1'b0, 3, 6);

    // Invalid selections.
    SpotSel = '0;
    step();
    run_event(1'b1, 1'b0, 2, 6);
    SpotSel = 8'b0001_0010;
    step();
    run_event(1'b1, 1'b0, 2, 6);

    // Fill the lot, reject one more, release spot 5.
    for (int i = 0; i < N; i++) begin
      select(i);
      step();
      run_event(1'b1, 1'b0, 1, 5);
    end
    select(0);
    step();
    run_event(1'b1, 1'b0, 2, 6);
    SpotSel = 8'b0001_0000;
    step();
    run_event(1'b0, 1'b1, 2, H + 2);

    // Simultaneous entry and exit, then a sensor held low for 100 cycles.
    run_event(1'b1, 1'b1, 3, 8);
    run_event(1'b0, 1'b1, 100, H + 4);

    // Second event 10 cycles into a grant hold.
    select(4);
    step();
    fall(1'b1, 1'b0);
    repeat (2) step();
    InSensor = 1'b1;
    repeat (3) step();
    SpotSel = '0;
    repeat (5) step();
    run_event(1'b1, 1'b0, 2, H + 6);

    // Reset between the sensor fall and the result edge.
    select(0);
    step();
    fall(1'b0, 1'b1);
    step();
    Reset = 1'b1;
    model_reset();
    #1 check_all();
    step();
    @(negedge Clk);
    InSensor = 1'b1; OutSensor = 1'b1; Reset = 1'b0;
    repeat (S + 6) step();

    // Randomised traffic.
    for (int t = 0; t < 150; t++) begin
      int kind;
      if ($urandom_range(0, 4) != 0) select($urandom_range(0, N - 1));
      else SpotSel = N'($urandom);
      step();
      kind = $urandom_range(0, 19);
      run_event(kind < 9, kind >= 9 && kind < 18 ? 1'b1 : kind >= 18,
                $urandom_range(1, 4), $urandom_range(4, 30));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
